// File: rtl/shreg_pkg.sv
// Shared FSM state type and width helpers for the shift-register chain loader.
package shreg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_LATCH,
    ST_FINISH
  } shreg_state_e;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // One spare code beyond the last chain so out-of-range indices can be presented and rejected.
  function automatic int chain_w(input int num_chains);
    return $clog2(num_chains + 1);
  endfunction

endpackage

// File: rtl/shreg_chain_loader_if.sv
// Request/serial bus between the control side and the chain loader.
// SHREG_READBACK_EN adds the SDI / readback signals.
interface shreg_chain_loader_if #(
  parameter int NUM_CHAINS = 2,
  parameter int MAX_LEN    = 128
);
  import shreg_pkg::*;

  localparam int LEN_W   = len_w(MAX_LEN);
  localparam int CHAIN_W = chain_w(NUM_CHAINS);

  logic                  start;
  logic                  abort;
  logic [CHAIN_W-1:0]    chain;
  logic [LEN_W-1:0]      len;
  logic [MAX_LEN-1:0]    data_in;
  logic                  sdo;
  logic                  sclk;
  logic [NUM_CHAINS-1:0] sel;
  logic [NUM_CHAINS-1:0] latch;
  logic                  busy;
  logic                  done;
  logic                  err;
`ifdef SHREG_READBACK_EN
  logic                  sdi;
  logic [MAX_LEN-1:0]    rb_data;
  logic                  rb_valid;

  modport master (
    output start, abort, chain, len, data_in, sdi,
    input  sdo, sclk, sel, latch, busy, done, err, rb_data, rb_valid
  );
  modport slave (
    input  start, abort, chain, len, data_in, sdi,
    output sdo, sclk, sel, latch, busy, done, err, rb_data, rb_valid
  );
`else
  modport master (
    output start, abort, chain, len, data_in,
    input  sdo, sclk, sel, latch, busy, done, err
  );
  modport slave (
    input  start, abort, chain, len, data_in,
    output sdo, sclk, sel, latch, busy, done, err
  );
`endif

endinterface

// File: rtl/shreg_bit_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 while running (held at 0 otherwise)
// and produces a registered shift strobe that is high for the second half-period.
module shreg_bit_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  input  logic strobe_en_i,
  output logic last_o,
  output logic strobe_o
);
  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  always_comb begin
    cnt_d = '0;
    if (run_i && (cnt_q != LAST)) cnt_d = cnt_q + CNT_W'(1);
    // strobe is decided from the next count so the output is a clean flop
    strobe_d = strobe_en_i && (cnt_d >= HALF);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign last_o   = run_i && (cnt_q == LAST);
  assign strobe_o = strobe_q;

endmodule

// File: rtl/shreg_chain_loader.sv
// Serial loader for NUM_CHAINS configuration shift-register chains: MSB-first shift, then latch pulse.
// Optional SDI readback capture enabled by SHREG_READBACK_EN.
//
// state  | meaning
// IDLE   | waiting for START; invalid requests pulse ERR
// SETUP  | SEL asserted for one bit period before shifting
// SHIFT  | LEN bit periods, SDO changes at period start, SCLK high second half
// LATCH  | LATCH[chain] high for one bit period, SEL held
// FINISH | DONE pulse, SEL/LATCH/BUSY low
module shreg_chain_loader import shreg_pkg::*; #(
  parameter int NUM_CHAINS = 2,
  parameter int MAX_LEN    = 128,
  parameter int CLK_DIV    = 4
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  shreg_chain_loader_if.slave ld_if
);
  localparam int LEN_W   = len_w(MAX_LEN);
  localparam int CHAIN_W = chain_w(NUM_CHAINS);

  shreg_state_e          state_q, state_d;
  logic [MAX_LEN-1:0]    shreg_q, shreg_d;
  logic [LEN_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CHAIN_W-1:0]    chain_q, chain_d;
  logic [NUM_CHAINS-1:0] sel_q, sel_d;
  logic [NUM_CHAINS-1:0] latch_q, latch_d;
  logic [NUM_CHAINS-1:0] onehot;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  req_ok;
  logic                  accept;
  logic                  run;
  logic                  tick_last;
  logic                  sclk;

  assign run = ((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_LATCH))
               && !ld_if.abort;

  shreg_bit_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .run_i       (run),
    .strobe_en_i (state_d == ST_SHIFT),
    .last_o      (tick_last),
    .strobe_o    (sclk)
  );

  always_comb begin
    req_ok = (ld_if.chain < CHAIN_W'(NUM_CHAINS)) && (ld_if.len != '0)
             && (ld_if.len <= LEN_W'(MAX_LEN));
    accept    = 1'b0;
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    chain_d   = chain_q;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ld_if.start) begin
          if (req_ok) begin
            accept    = 1'b1;
            state_d   = ST_SETUP;
            // left-align the payload so bit LEN-1 sits at the MSB
            shreg_d   = ld_if.data_in << (LEN_W'(MAX_LEN) - ld_if.len);
            bit_cnt_d = ld_if.len;
            chain_d   = ld_if.chain;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tick_last) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick_last) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
          if (bit_cnt_q == LEN_W'(1)) state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (tick_last) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ld_if.abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end

    // outputs are registered from the next state so they change cleanly on the edge
    onehot  = NUM_CHAINS'(1) << chain_d;
    busy_d  = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_LATCH);
    sel_d   = busy_d ? onehot : '0;
    latch_d = (state_d == ST_LATCH) ? onehot : '0;
    sdo_d   = (state_d == ST_SHIFT) && shreg_d[MAX_LEN-1];
    done_d  = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      chain_q   <= '0;
      sel_q     <= '0;
      latch_q   <= '0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      chain_q   <= chain_d;
      sel_q     <= sel_d;
      latch_q   <= latch_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ld_if.sdo   = sdo_q;
  assign ld_if.sclk  = sclk;
  assign ld_if.sel   = sel_q;
  assign ld_if.latch = latch_q;
  assign ld_if.busy  = busy_q;
  assign ld_if.done  = done_q;
  assign ld_if.err   = err_q;

`ifdef SHREG_READBACK_EN
  logic [MAX_LEN-1:0] rb_q, rb_d;
  logic               rb_valid_q;
  logic               sclk_prev_q;

  always_comb begin
    rb_d = rb_q;
    if (accept) begin
      rb_d = '0;
    end else if (sclk && !sclk_prev_q) begin
      rb_d = {rb_q[MAX_LEN-2:0], ld_if.sdi};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rb_q        <= '0;
      rb_valid_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      rb_q        <= rb_d;
      rb_valid_q  <= done_d;
      sclk_prev_q <= sclk;
    end
  end

  assign ld_if.rb_data  = rb_q;
  assign ld_if.rb_valid = rb_valid_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
